// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-index counter width for a given operand width (at least one bit).
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int DEF_WIDTH = 4;
  localparam int CNT_W     = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first, one full-subtractor cell and a registered borrow.
import serial_subtractor_pkg::*;

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow,
  output logic             zero
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] opa, opb, res, res_nxt;
  logic [CW-1:0]    cnt;
  logic             borrow, d_bit, b_nxt;

  full_subtractor u_fs (
    .a    (opa[cnt]),
    .b    (opb[cnt]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (b_nxt)
  );

  // Result including the bit being produced this cycle, so the final edge sees all bits.
  always_comb begin
    res_nxt      = res;
    res_nxt[cnt] = d_bit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      res      <= '0;
      cnt      <= '0;
      borrow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa    <= a;
            opb    <= b;
            borrow <= bin;
            res    <= '0;
            cnt    <= '0;
            ready  <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          res    <= res_nxt;
          borrow <= b_nxt;
          if (cnt == LAST) begin
            state    <= DONE;
            done     <= 1'b1;
            diff     <= res_nxt;
            bout     <= b_nxt;
            overflow <= (opa[WIDTH-1] != opb[WIDTH-1]) && (res_nxt[WIDTH-1] != opa[WIDTH-1]);
            zero     <= (res_nxt == '0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes diff = a - b - bin one bit per clock, LSB first, using a single one-bit full-subtractor cell with a registered borrow.
- Companion to the team's parallel ripple-carry adder. It provides the subtract direction of the same datapath.
- It trades latency for area and exposes a start/ready/done handshake for use by the lab ALU/FSM datapath.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..16).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- a  input  WIDTH  minuend; captured on the accepted start.
- b  input  WIDTH  subtrahend; captured on the accepted start.
- bin  input  1  borrow-in; captured on the accepted start.
- ready  output  1  high in IDLE; block can accept start.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  registered difference.
- bout  output  1  final borrow-out (unsigned a < b+bin).
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  diff == 0.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (reset).
- Reset values (at the edge where reset=1): state=IDLE, ready=1, done=0, diff=0, bout=0, overflow=0, zero=0, internal bit counter=0, borrow=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: ready=1. If start=1 at an edge, latch a, b, bin into operand registers, load borrow<=bin, count<=0, and go to RUN. Otherwise stay in IDLE.
  - RUN: ready=0. Each edge processes bit i=count:
    - d_i = a_i ^ b_i ^ borrow
    - borrow <= (~a_i & b_i) | (~a_i & borrow) | (b_i & borrow)
    - d_i is stored into the internal result register at bit i; count increments.
    - When count == WIDTH-1 at the edge, go to DONE and update the output registers: diff=full result, bout=final borrow, overflow=(a_msb != b_msb) & (diff_msb != a_msb) using latched operands, zero=(diff==0).
  - DONE: done=1, ready=0 for exactly one cycle; next edge goes to IDLE.
- Latency: start accepted at edge k; RUN spans edges k+1..k+WIDTH; done is high in the cycle after edge k+WIDTH. With WIDTH=4, done appears 5 cycles after start is sampled.
- Output holding:
  - diff, bout, overflow, zero change only on entry to DONE (or on reset).
  - They hold the previous result throughout IDLE and RUN, until the next completion.
- Input capture: a, b, bin changing during RUN has no effect; only the values latched at start are used.
- start while ready=0 (RUN or DONE) is ignored, not queued. start held high continuously starts a new operation each time IDLE is re-entered: done, then one IDLE cycle, then RUN.
- Reset mid-RUN or during DONE aborts the operation. No done pulse is issued, and outputs return to their reset values.
- Reset has priority over start in the same cycle.
- Boundaries:
  - a=b, bin=0 gives zero=1.
  - a=0, b=0, bin=1 gives all-ones with bout=1.
  - The counter never exceeds WIDTH-1.

Decomposition:
- Shared package (constants):
  - FSM state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Counter width constant CNT_W = clog2(WIDTH).
- Sub-module full_subtractor (a, b, bin -> d, bout) is the one-bit cell, instantiated once. It is the subtract counterpart of the existing full-adder cell.
- All remaining logic (FSM, counter, shift/index register, flag logic) lives in serial_subtractor.

Test Plan:
- Basic subtract: reset, then start with a=4'd7, b=4'd3, bin=0 -> done pulses exactly 5 cycles after start; diff=4'b0100, bout=0, overflow=0, zero=0; ready returns high the cycle after done.
- Borrow out: a=4'd3, b=4'd7, bin=0 -> diff=4'b1100, bout=1, overflow=0. Then a=4'd0, b=4'd0, bin=1 -> diff=4'b1111, bout=1.
- Signed overflow and zero: a=4'b1000, b=4'b0001 -> diff=4'b0111, overflow=1, bout=0. Then a=b=4'd5 -> diff=0, zero=1.
- Handshake robustness:
  - Pulse start again at cycles 2 and 4 of a RUN and change a/b mid-run -> only one done; result reflects the operands latched at start.
  - Outputs hold the prior result until the new done.
- Reset mid-operation: assert reset for one cycle during RUN cycle 2 -> no done pulse; diff=0, flags=0, ready=1 the next cycle. A subsequent start of 9-4 gives diff=4'b0101 correctly.
